// File: rtl/cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// cla_slice_sequencer
//
// Purpose:
//   Multi-cycle wide adder/subtractor controller. One external 16-bit
//   carry-lookahead slice is reused for N_SLICE passes, least significant
//   slice first. The inter-slice carry is held in a register between passes
//   and is rebuilt from the slice group signals as G | (P & carry_in).
//   Subtraction is A + ~B + 1. The operand B is inverted once, when the
//   operation is accepted.
//
// Parameters:
//   N_SLICE   number of 16-bit passes (2..8). Operand width W = 16*N_SLICE.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (ready only while idle)
//   in_a, in_b              W-bit operands
//   in_cin                  carry-in for add (ignored for subtract)
//   in_sub                  1 = A - B
//   out_valid / out_ready   result handshake
//   out_r                   W-bit sum/difference
//   out_cout                carry out of the MSB slice (1 = no borrow on sub)
//   out_ovf                 signed overflow
//   slice_a/b/c             drive to the shared slice (zero outside RUN)
//   slice_r/p/g             slice sum, group propagate, group generate
// ---------------------------------------------------------------------------
module cla_slice_sequencer #(
  parameter int N_SLICE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*N_SLICE-1:0]   in_a,
  input  logic [16*N_SLICE-1:0]   in_b,
  input  logic                    in_cin,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*N_SLICE-1:0]   out_r,
  output logic                    out_cout,
  output logic                    out_ovf,
  output logic [15:0]             slice_a,
  output logic [15:0]             slice_b,
  output logic                    slice_c,
  input  logic [15:0]             slice_r,
  input  logic                    slice_p,
  input  logic                    slice_g
);

  localparam int W     = 16 * N_SLICE;
  localparam int IDX_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic [W-1:0]     out_r_q, out_r_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             carry_next;

  // Carry leaving the slice that is currently being processed.
  assign carry_next = slice_g | (slice_p & carry_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_r     = out_r_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

  // Next-state and slice drive. The slice inputs are only non-zero while
  // running. The result slice for the current index is written back into
  // out_r on every RUN edge. The sign check for overflow uses the latched,
  // already-inverted B. For a subtract, that is the sign of the
  // effective addend.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    out_r_d    = out_r_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;
    slice_a    = 16'h0000;
    slice_b    = 16'h0000;
    slice_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_cin;
          out_r_d = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        slice_c = carry_q;
        for (int i = 0; i < N_SLICE; i++) begin
          if (idx_q == IDX_W'(i)) begin
            slice_a              = op_a_q[16*i +: 16];
            slice_b              = op_b_q[16*i +: 16];
            out_r_d[16*i +: 16]  = slice_r;
          end
        end
        carry_d = carry_next;
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          out_cout_d = carry_next;
          out_ovf_d  = (op_a_q[W-1] == op_b_q[W-1]) & (slice_r[15] != op_a_q[W-1]);
          idx_d      = '0;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset abandons any
  // operation in flight and clears every visible output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      out_r_q    <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      out_r_q    <= out_r_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_slice_sequencer
//
// Directed bench for cla_slice_sequencer (default N_SLICE = 4, 64-bit).
// The bench provides a behavioural 16-bit slice (sum, group P, group G).
// It applies hand-computed vectors for carry ripple, subtract, signed
// overflow, backpressure and mid-operation reset. It then runs three random
// back-to-back operations and checks them against a reference model.
// ---------------------------------------------------------------------------
module tb_cla_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_r;
  logic        out_cout;
  logic        out_ovf;
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic        slice_c;
  logic [15:0] slice_r;
  logic        slice_p;
  logic        slice_g;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [3:0]  passC;
  logic [15:0] pass0B;

  cla_slice_sequencer #(.N_SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_c   (slice_c),
    .slice_r   (slice_r),
    .slice_p   (slice_p),
    .slice_g   (slice_g)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural model of the external 16-bit slice.
  logic [16:0] sumFull;
  logic [16:0] sumNoCin;
  always_comb begin
    sumFull  = {1'b0, slice_a} + {1'b0, slice_b} + {16'h0000, slice_c};
    sumNoCin = {1'b0, slice_a} + {1'b0, slice_b};
    slice_r  = sumFull[15:0];
    slice_p  = &(slice_a ^ slice_b);
    slice_g  = sumNoCin[16];
  end

  // Reference result packed as {ovf, cout, r}.
  function automatic logic [65:0] refModel(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
    logic [63:0] bb;
    logic [64:0] s;
    logic        ovf;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {64'd0, (sub | cin)};
    ovf = (a[63] == bb[63]) && (s[63] != a[63]);
    return {ovf, s[64], s[63:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic sub);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
  endtask

  // Accept one operation, walk the four passes recording the slice carry,
  // then check latency and the final result. The task leaves the DUT in DONE.
  task automatic doOperation(input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic sub,
                             input logic [63:0] expR, input logic expCout,
                             input logic expOvf, input string tag);
    applyStimulus(a, b, cin, sub);
    checkBit({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      passC[p] = slice_c;
      if (p == 0) pass0B = slice_b;
      checkBit({tag, "_valid_early"}, out_valid, 1'b0);
      tick();
    end
    checkBit({tag, "_out_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_r"}, out_r, expR);
    checkBit({tag, "_cout"}, out_cout, expCout);
    checkBit({tag, "_ovf"}, out_ovf, expOvf);
  endtask

  logic [63:0] rA [3];
  logic [63:0] rB [3];
  logic        rCin [3];
  logic        rSub [3];
  logic [65:0] expect66;
  int          acceptCycle;
  int          prevAccept;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_out_r", out_r, 64'h0);
    checkBit("reset_cout", out_cout, 1'b0);
    checkBit("reset_ovf", out_ovf, 1'b0);
    checkBit("reset_in_ready", in_ready, 1'b1);
    checkBit("reset_slice_c", slice_c, 1'b0);
    rst_n = 1'b1;
    tick();

    // Add with carry rippling through every slice
    doOperation(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0, 1'b1, 1'b0, "add_ripple");
    checkOutput("add_ripple_slice_c", {60'd0, passC}, 64'hE);
    tick();

    // Subtract with in_cin set (must be ignored)
    doOperation(64'h0000_0000_0001_0000, 64'h1, 1'b1, 1'b1,
                64'h0000_0000_0000_FFFF, 1'b1, 1'b0, "sub_borrow");
    checkOutput("sub_slice_b_pass0", {48'd0, pass0B}, 64'hFFFE);
    tick();

    // Signed overflow on add and on subtract
    doOperation(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf_add");
    tick();
    doOperation(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "ovf_sub");
    tick();

    // Backpressure: result held in DONE, new request ignored
    out_ready = 1'b0;
    doOperation(64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0, 1'b0, "bp_first");
    applyStimulus(64'd100, 64'd1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkBit("bp_hold_valid", out_valid, 1'b1);
      checkBit("bp_hold_in_ready", in_ready, 1'b0);
      checkOutput("bp_hold_r", out_r, 64'd8);
    end
    out_ready = 1'b1;
    tick();
    checkBit("bp_release_in_ready", in_ready, 1'b1);
    checkBit("bp_release_valid", out_valid, 1'b0);
    checkOutput("bp_release_r_kept", out_r, 64'd8);
    tick();
    in_valid = 1'b0;
    checkBit("bp_pending_accepted", in_ready, 1'b0);
    checkOutput("bp_r_cleared", out_r, 64'h0);
    for (int k = 0; k < 4; k++) tick();
    checkBit("bp_pending_valid", out_valid, 1'b1);
    checkOutput("bp_pending_r", out_r, 64'd99);
    checkBit("bp_pending_cout", out_cout, 1'b1);
    checkBit("bp_pending_ovf", out_ovf, 1'b0);
    tick();

    // Asynchronous reset after two passes
    applyStimulus(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("midrun_partial_r", out_r, 64'h0000_0000_4444_5555);
    checkOutput("midrun_slice_a", {48'd0, slice_a}, 64'h2222);
    rst_n = 1'b0;
    #1;
    checkBit("midrun_rst_valid", out_valid, 1'b0);
    checkOutput("midrun_rst_r", out_r, 64'h0);
    checkOutput("midrun_rst_slice_a", {48'd0, slice_a}, 64'h0);
    checkOutput("midrun_rst_slice_b", {48'd0, slice_b}, 64'h0);
    checkBit("midrun_rst_slice_c", slice_c, 1'b0);
    checkBit("midrun_rst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    doOperation(64'd1000, 64'd234, 1'b1, 1'b0, 64'd1235, 1'b0, 1'b0, "post_reset");
    tick();

    // Back-to-back random operations with in_valid held high
    for (int k = 0; k < 3; k++) begin
      rA[k]   = {$urandom, $urandom};
      rB[k]   = {$urandom, $urandom};
      rCin[k] = 1'($urandom_range(0, 1));
      rSub[k] = 1'($urandom_range(0, 1));
    end
    out_ready  = 1'b1;
    prevAccept = -1;
    applyStimulus(rA[0], rB[0], rCin[0], rSub[0]);
    for (int k = 0; k < 3; k++) begin
      checkBit("b2b_in_ready", in_ready, 1'b1);
      tick();
      acceptCycle = cycle;
      checkBit("b2b_accepted", in_ready, 1'b0);
      if (prevAccept >= 0)
        checkOutput("b2b_interval", 64'(acceptCycle - prevAccept), 64'd6);
      prevAccept = acceptCycle;
      if (k < 2) applyStimulus(rA[k+1], rB[k+1], rCin[k+1], rSub[k+1]);
      else       in_valid = 1'b0;
      for (int p = 0; p < 4; p++) tick();
      expect66 = refModel(rA[k], rB[k], rCin[k], rSub[k]);
      checkBit("b2b_valid", out_valid, 1'b1);
      checkOutput("b2b_r", out_r, expect66[63:0]);
      checkBit("b2b_cout", out_cout, expect66[64]);
      checkBit("b2b_ovf", out_ovf, expect66[65]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
